// File: rtl/rhythm_scheduler_if.sv
// Bundle of key, timing-configuration and move-handshake signals for rhythm_scheduler.
// i_* are driven toward the scheduler, o_* are produced by it.
interface rhythm_scheduler_if;
  logic        i_j_press;
  logic        i_k_press;
  logic [15:0] i_beat_period;
  logic [7:0]  i_window;
  logic        i_move_ack;
  logic        o_beat;
  logic        o_move_req;
  logic [1:0]  o_move_sel;
  logic        o_hit;
  logic        o_miss;
  logic [15:0] o_score;
  logic [7:0]  o_streak;

  modport master (
    output i_j_press, i_k_press, i_beat_period, i_window, i_move_ack,
    input  o_beat, o_move_req, o_move_sel, o_hit, o_miss, o_score, o_streak
  );

  modport slave (
    input  i_j_press, i_k_press, i_beat_period, i_window, i_move_ack,
    output o_beat, o_move_req, o_move_sel, o_hit, o_miss, o_score, o_streak
  );
endinterface

// File: rtl/rhythm_scheduler.sv
// Beat-synchronous key judge: free-running beat counter, chord detection, hit/miss
// scoring and a move request held until the animation side acknowledges it.
module rhythm_scheduler (
  input logic               i_clk,
  input logic               i_rst,
  rhythm_scheduler_if.slave io_bus
);

  // state   | meaning
  // S_IDLE  | waiting for a key press edge
  // S_CHORD | one key seen, waiting up to 4 cycles for the other key
  // S_JUDGE | single cycle: grade the press, update score/streak
  // S_ISSUE | move request held until acknowledged
  typedef enum logic [1:0] {S_IDLE, S_CHORD, S_JUDGE, S_ISSUE} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt;
  logic        r_beat;
  logic        r_j_prev, r_k_prev;
  logic [1:0]  r_chord_tmr;
  logic        r_key_j;
  logic        r_combo;
  logic [15:0] r_c;
  logic        r_used;
  logic        r_hit, r_miss;
  logic [1:0]  r_move_sel;
  logic [15:0] r_score;
  logic [7:0]  r_streak;

  logic [15:0] w_period, w_c_far, w_dist, w_score_sat;
  logic [16:0] w_score_sum;
  logic        w_wrap, w_j_edge, w_k_edge, w_hit_ok;
  logic        w_start, w_start_combo, w_to_combo;

  assign w_period    = (io_bus.i_beat_period < 16'd4) ? 16'd4 : io_bus.i_beat_period;
  assign w_wrap      = (r_cnt >= w_period - 16'd1);
  assign w_j_edge    = io_bus.i_j_press & ~r_j_prev;
  assign w_k_edge    = io_bus.i_k_press & ~r_k_prev;
  assign w_c_far     = w_period - r_c;
  assign w_dist      = (r_c < w_c_far) ? r_c : w_c_far;
  assign w_hit_ok    = (w_dist <= {8'd0, io_bus.i_window}) && !r_used;
  assign w_score_sum = {1'b0, r_score} + (r_combo ? 17'd3 : 17'd1);
  assign w_score_sat = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];

  always_comb begin
    w_state_nxt   = r_state;
    w_start       = 1'b0;
    w_start_combo = 1'b0;
    w_to_combo    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_j_edge && w_k_edge) begin
          w_state_nxt   = S_JUDGE;
          w_start       = 1'b1;
          w_start_combo = 1'b1;
        end else if (w_j_edge || w_k_edge) begin
          w_state_nxt = S_CHORD;
          w_start     = 1'b1;
        end
      end
      S_CHORD: begin
        if (r_key_j ? w_k_edge : w_j_edge) begin
          w_state_nxt = S_JUDGE;
          w_to_combo  = 1'b1;
        end else if (r_chord_tmr == 2'd3) begin
          w_state_nxt = S_JUDGE;
        end
      end
      S_JUDGE: w_state_nxt = S_ISSUE;
      S_ISSUE: if (io_bus.i_move_ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 16'd0;
      r_beat      <= 1'b0;
      r_j_prev    <= 1'b1;
      r_k_prev    <= 1'b1;
      r_chord_tmr <= 2'd0;
      r_key_j     <= 1'b0;
      r_combo     <= 1'b0;
      r_c         <= 16'd0;
      r_used      <= 1'b0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_move_sel  <= 2'd0;
      r_score     <= 16'd0;
      r_streak    <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_j_prev <= io_bus.i_j_press;
      r_k_prev <= io_bus.i_k_press;
      r_cnt    <= w_wrap ? 16'd0 : r_cnt + 16'd1;
      r_beat   <= w_wrap;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;

      if (w_start) begin
        r_c         <= r_cnt;
        r_combo     <= w_start_combo;
        r_key_j     <= w_j_edge;
        r_chord_tmr <= 2'd0;
      end else if (r_state == S_CHORD) begin
        r_chord_tmr <= r_chord_tmr + 2'd1;
        if (w_to_combo) r_combo <= 1'b1;
      end

      // A judgement in the mid-beat cycle still marks the beat as used.
      if (r_state == S_JUDGE) begin
        r_used <= 1'b1;
        if (w_hit_ok) begin
          r_hit      <= 1'b1;
          r_score    <= w_score_sat;
          r_streak   <= (r_streak == 8'hFF) ? r_streak : r_streak + 8'd1;
          r_move_sel <= r_combo ? 2'd1 : 2'd0;
        end else begin
          r_miss     <= 1'b1;
          r_streak   <= 8'd0;
          r_move_sel <= 2'd2;
        end
      end else if (r_cnt == (w_period >> 1)) begin
        r_used <= 1'b0;
      end
    end
  end

  assign io_bus.o_beat     = r_beat;
  assign io_bus.o_move_req = (r_state == S_ISSUE);
  assign io_bus.o_move_sel = r_move_sel;
  assign io_bus.o_hit      = r_hit;
  assign io_bus.o_miss     = r_miss;
  assign io_bus.o_score    = r_score;
  assign io_bus.o_streak   = r_streak;

endmodule

// File: tb/tb_rhythm_scheduler.sv
// Bench for rhythm_scheduler: event-level reference model checked every cycle,
// directed beat/judge scenarios with literal expectations, then random key traffic.
module tb_rhythm_scheduler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rhythm_scheduler_if bus_if();
  rhythm_scheduler dut (.i_clk(clk), .i_rst(rst), .io_bus(bus_if));

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: beat position, press events stamped with edge numbers.
  int   m_cnt, m_t, m_first, m_judge, m_c;
  int   e_score, e_streak;
  bit   m_pending, m_issue, m_combo, m_key_j, m_used, m_jp, m_kp;
  logic e_beat, e_req, e_hit, e_miss;
  logic [1:0] e_sel;

  always @(posedge clk) begin
    int p, d;
    bit je, ke, judged, ok;
    p = (bus_if.i_beat_period < 4) ? 4 : int'(bus_if.i_beat_period);
    if (rst) begin
      m_cnt = 0; m_t = 0; m_first = 0; m_judge = 0; m_c = 0;
      e_score = 0; e_streak = 0;
      m_pending = 0; m_issue = 0; m_combo = 0; m_key_j = 0; m_used = 0;
      m_jp = 1; m_kp = 1;
      e_beat = 0; e_req = 0; e_hit = 0; e_miss = 0; e_sel = 2'd0;
    end else begin
      je = bus_if.i_j_press && !m_jp;
      ke = bus_if.i_k_press && !m_kp;
      e_hit = 0; e_miss = 0; judged = 0;
      if (m_issue) begin
        if (bus_if.i_move_ack) m_issue = 0;
      end else if (m_pending && m_t == m_judge) begin
        d = (m_c < p - m_c) ? m_c : p - m_c;
        ok = (d <= int'(bus_if.i_window)) && !m_used;
        if (ok) begin
          e_hit = 1;
          e_score = (e_score + (m_combo ? 3 : 1) > 65535) ? 65535 : e_score + (m_combo ? 3 : 1);
          e_streak = (e_streak >= 255) ? 255 : e_streak + 1;
          e_sel = m_combo ? 2'd1 : 2'd0;
        end else begin
          e_miss = 1; e_streak = 0; e_sel = 2'd2;
        end
        judged = 1; m_pending = 0; m_issue = 1;
      end else if (m_pending) begin
        if (!m_combo && (m_key_j ? ke : je)) begin
          m_combo = 1; m_judge = m_t + 1;
        end
      end else if (je || ke) begin
        m_pending = 1; m_c = m_cnt; m_first = m_t;
        if (je && ke) begin m_combo = 1; m_judge = m_t + 1; end
        else begin m_combo = 0; m_key_j = je; m_judge = m_t + 5; end
      end
      if (judged) m_used = 1;
      else if (m_cnt == p / 2) m_used = 0;
      e_beat = (m_cnt >= p - 1);
      m_cnt = e_beat ? 0 : m_cnt + 1;
      e_req = m_issue;
      m_jp = bus_if.i_j_press; m_kp = bus_if.i_k_press;
      m_t++;
    end
  end

  task automatic check(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en)
      check("cycle {beat,req,sel,hit,miss,score,streak}",
            {bus_if.o_beat, bus_if.o_move_req, bus_if.o_move_sel, bus_if.o_hit,
             bus_if.o_miss, bus_if.o_score, bus_if.o_streak},
            {e_beat, e_req, e_sel, e_hit, e_miss, 16'(e_score), 8'(e_streak)});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cnt(input int v);
    int n;
    n = 0;
    while (m_cnt != v && n < 400) begin @(negedge clk); n++; end
    if (m_cnt != v) begin
      n_vec++; n_err++;
      $display("FAIL wait_cnt: beat position %0d, required %0d", m_cnt, v);
    end
  endtask

  task automatic beat_gap(input string nm, input int exp);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (bus_if.o_beat !== 1'b1 && n < 400);
    check(nm, n, exp);
  endtask

  task automatic keys(input logic j, input logic k);
    bus_if.i_j_press = j;
    bus_if.i_k_press = k;
  endtask

  task automatic random_seg(input int ncyc);
    rst = 1'b1;
    bus_if.i_beat_period = 16'($urandom_range(2, 24));
    bus_if.i_window = 8'($urandom_range(0, 14));
    keys(1'b0, 1'b0);
    bus_if.i_move_ack = 1'b0;
    tick(1);
    rst = 1'b0;
    repeat (ncyc) begin
      tick(1);
      if ($urandom_range(0, 3) == 0) bus_if.i_j_press = ~bus_if.i_j_press;
      if ($urandom_range(0, 3) == 0) bus_if.i_k_press = ~bus_if.i_k_press;
      bus_if.i_move_ack = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 299) == 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_if.i_beat_period = 16'd100;
    bus_if.i_window = 8'd5;
    keys(1'b0, 1'b0);
    bus_if.i_move_ack = 1'b0;
    tick(3);
    chk_en = 1'b1;
    check("reset_score", bus_if.o_score, 0);
    check("reset_move_req", bus_if.o_move_req, 0);
    rst = 1'b0;

    // Free-running beat at P=100
    beat_gap("first_beat_cycle", 100);
    beat_gap("second_beat_gap", 100);
    check("idle_move_req", bus_if.o_move_req, 0);

    // Punch at Cnt=97: D=3 within window 5
    wait_cnt(97);
    keys(1'b1, 1'b0);
    tick(6);
    check("punch_hit", bus_if.o_hit, 1);
    check("punch_score", bus_if.o_score, 1);
    check("punch_streak", bus_if.o_streak, 1);
    check("punch_sel", bus_if.o_move_sel, 0);
    keys(1'b0, 1'b0);
    tick(3);
    check("req_held", bus_if.o_move_req, 1);
    check("hit_one_cycle", bus_if.o_hit, 0);
    bus_if.i_move_ack = 1'b1;
    tick(1);
    check("req_dropped", bus_if.o_move_req, 0);
    bus_if.i_move_ack = 1'b0;

    // Chord J then K two cycles later at Cnt=2
    wait_cnt(50);
    wait_cnt(2);
    keys(1'b1, 1'b0);
    tick(2);
    keys(1'b1, 1'b1);
    tick(2);
    check("combo_hit", bus_if.o_hit, 1);
    check("combo_score", bus_if.o_score, 4);
    check("combo_sel", bus_if.o_move_sel, 1);
    check("combo_streak", bus_if.o_streak, 2);
    keys(1'b0, 1'b0);
    bus_if.i_move_ack = 1'b1;
    tick(1);
    bus_if.i_move_ack = 1'b0;

    // Off-beat press at Cnt=30
    wait_cnt(50);
    wait_cnt(30);
    keys(1'b1, 1'b0);
    tick(6);
    check("off_miss", bus_if.o_miss, 1);
    check("off_streak", bus_if.o_streak, 0);
    check("off_sel", bus_if.o_move_sel, 2);
    check("off_score", bus_if.o_score, 4);
    keys(1'b0, 1'b0);
    bus_if.i_move_ack = 1'b1;
    tick(1);
    bus_if.i_move_ack = 1'b0;

    // Second press inside the same beat half is a miss
    wait_cnt(50);
    wait_cnt(0);
    keys(1'b1, 1'b1);
    tick(1);
    keys(1'b0, 1'b0);
    tick(1);
    check("first_of_pair_hit", bus_if.o_hit, 1);
    check("first_of_pair_score", bus_if.o_score, 7);
    bus_if.i_move_ack = 1'b1;
    tick(1);
    bus_if.i_move_ack = 1'b0;
    wait_cnt(4);
    keys(1'b1, 1'b1);
    tick(1);
    keys(1'b0, 1'b0);
    tick(1);
    check("used_miss", bus_if.o_miss, 1);
    check("used_score", bus_if.o_score, 7);
    check("used_req", bus_if.o_move_req, 1);

    // Reset while in ISSUE
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_issue_req", bus_if.o_move_req, 0);
    check("rst_issue_score", bus_if.o_score, 0);

    // Period shrinks below the current count
    wait_cnt(60);
    bus_if.i_beat_period = 16'd20;
    tick(1);
    check("shrink_beat", bus_if.o_beat, 1);
    tick(1);
    check("shrink_beat_once", bus_if.o_beat, 0);

    // Beat_Period=2 clamps to 4
    rst = 1'b1;
    bus_if.i_beat_period = 16'd2;
    tick(1);
    rst = 1'b0;
    beat_gap("p2_first_beat", 4);
    beat_gap("p2_beat_gap", 4);

    repeat (3) random_seg(800);

    // Drive score and streak into saturation with back-to-back combos at P=4
    rst = 1'b1;
    bus_if.i_beat_period = 16'd2;
    bus_if.i_window = 8'd255;
    keys(1'b0, 1'b0);
    bus_if.i_move_ack = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 21846; i++) begin
      wait_cnt(3);
      keys(1'b1, 1'b1);
      tick(1);
      keys(1'b0, 1'b0);
      tick(2);
    end
    tick(2);
    check("sat_score", bus_if.o_score, 16'hFFFF);
    check("sat_streak", bus_if.o_streak, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
